// File: rtl/exu_muldiv_unit.sv
// RV32M multi-cycle multiply/divide unit: iterative shift-add multiplier and restoring divider.
// Define EXU_MDU_FAST_MUL_EN to replace the iterative multiplier with a single-cycle combinational one.
module exu_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int GPR_AW   = 5,
    parameter int MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic [2:0]        req_op,
    input  logic [XLEN-1:0]   req_src1,
    input  logic [XLEN-1:0]   req_src2,
    input  logic [GPR_AW-1:0] req_rd,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [GPR_AW-1:0] rsp_rd,
    output logic [XLEN-1:0]   rsp_data,
    output logic              busy
);

    localparam int W2       = 2 * XLEN;
    localparam int CNT_W    = $clog2(XLEN);
    localparam int MUL_ITER = XLEN / MUL_STEP;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t state, state_nxt;

    // Handshake: a request transfers on a rising edge where req_vld && req_rdy;
    // a response transfers on a rising edge where rsp_vld && rsp_rdy.
    logic accept;
    assign req_rdy = (state == S_IDLE) && !flush;
    assign accept  = req_vld && req_rdy;
    assign rsp_vld = (state == S_DONE);
    assign busy    = (state != S_IDLE);

    logic [CNT_W-1:0] cnt;
    logic             sel_hi;   // upper product half for MULH*, remainder for REM*

    // Divider request decode
    logic            div_signed, src1_neg, src2_neg, div_by_zero, div_ovf, div_early;
    logic [XLEN-1:0] early_data, abs1, abs2;
    assign div_signed  = !req_op[0];
    assign src1_neg    = div_signed && req_src1[XLEN-1];
    assign src2_neg    = div_signed && req_src2[XLEN-1];
    assign div_by_zero = (req_src2 == '0);
    assign div_ovf     = div_signed && (req_src1 == MIN_INT) && (req_src2 == '1);
    assign div_early   = div_by_zero || div_ovf;
    assign early_data  = req_op[1] ? (div_by_zero ? req_src1 : '0)
                                   : (div_by_zero ? '1 : MIN_INT);
    assign abs1 = src1_neg ? -req_src1 : req_src1;
    assign abs2 = src2_neg ? -req_src2 : req_src2;

    // Multiplier operand signedness: MULH s*s, MULHSU s*u, MUL/MULHU u*u
    logic            mul_a_signed, mul_b_signed;
    logic [W2-1:0]   a_ext;
    assign mul_a_signed = req_op[1] ^ req_op[0];
    assign mul_b_signed = (req_op[1:0] == 2'b01);
    assign a_ext = {{XLEN{mul_a_signed && req_src1[XLEN-1]}}, req_src1};

`ifdef EXU_MDU_FAST_MUL_EN
    logic [W2-1:0] b_ext, fast_prod;
    logic [XLEN-1:0] fast_data;
    assign b_ext     = {{XLEN{mul_b_signed && req_src2[XLEN-1]}}, req_src2};
    assign fast_prod = a_ext * b_ext;
    assign fast_data = (req_op[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[W2-1:XLEN];
`else
    // A negative signed multiplier is treated as unsigned and corrected by -(a << XLEN) up front.
    logic [W2-1:0]   acc, mcand, mul_sum, acc_init;
    logic [XLEN-1:0] mplier, mul_final;
    assign acc_init = (mul_b_signed && req_src2[XLEN-1]) ? -{req_src1, {XLEN{1'b0}}} : '0;

    always_comb begin
        mul_sum = acc;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier[i]) mul_sum = mul_sum + (mcand << i);
        end
    end
    assign mul_final = sel_hi ? mul_sum[W2-1:XLEN] : mul_sum[XLEN-1:0];
`endif

    // Restoring divider step on magnitudes
    logic [XLEN-1:0] quo, rem, dvsr, q_step, r_step, div_final;
    logic [XLEN:0]   r_sh, diff;
    logic            q_neg, r_neg;
    always_comb begin
        r_sh = {rem, quo[XLEN-1]};
        diff = r_sh - {1'b0, dvsr};
        if (!diff[XLEN]) begin
            r_step = diff[XLEN-1:0];
            q_step = {quo[XLEN-2:0], 1'b1};
        end else begin
            r_step = r_sh[XLEN-1:0];
            q_step = {quo[XLEN-2:0], 1'b0};
        end
    end
    assign div_final = sel_hi ? (r_neg ? -r_step : r_step) : (q_neg ? -q_step : q_step);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) begin
                if (req_op[2])  state_nxt = div_early ? S_DONE : S_DIV;
`ifdef EXU_MDU_FAST_MUL_EN
                else            state_nxt = S_DONE;
`else
                else            state_nxt = S_MUL;
`endif
            end
            S_MUL:  if (cnt == '0) state_nxt = S_DONE;
            S_DIV:  if (cnt == '0) state_nxt = S_DONE;
            S_DONE: if (rsp_rdy)   state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            sel_hi   <= 1'b0;
            rsp_rd   <= '0;
            rsp_data <= '0;
            quo      <= '0;
            rem      <= '0;
            dvsr     <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
`ifndef EXU_MDU_FAST_MUL_EN
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
`endif
        end else if (!flush) begin
            if (accept) begin
                rsp_rd <= req_rd;
                sel_hi <= req_op[2] ? req_op[1] : (req_op[1:0] != 2'b00);
                if (req_op[2]) begin
                    if (div_early) begin
                        rsp_data <= early_data;
                    end else begin
                        quo   <= abs1;
                        rem   <= '0;
                        dvsr  <= abs2;
                        q_neg <= src1_neg ^ src2_neg;
                        r_neg <= src1_neg;
                        cnt   <= CNT_W'(XLEN - 1);
                    end
                end else begin
`ifdef EXU_MDU_FAST_MUL_EN
                    rsp_data <= fast_data;
`else
                    acc    <= acc_init;
                    mcand  <= a_ext;
                    mplier <= req_src2;
                    cnt    <= CNT_W'(MUL_ITER - 1);
`endif
                end
            end
`ifndef EXU_MDU_FAST_MUL_EN
            if (state == S_MUL) begin
                acc    <= mul_sum;
                mcand  <= mcand << MUL_STEP;
                mplier <= mplier >> MUL_STEP;
                cnt    <= cnt - 1'b1;
                if (cnt == '0) rsp_data <= mul_final;
            end
`endif
            if (state == S_DIV) begin
                quo <= q_step;
                rem <= r_step;
                cnt <= cnt - 1'b1;
                if (cnt == '0) rsp_data <= div_final;
            end
        end
    end

endmodule

// File: tb/tb_exu_muldiv_unit.sv
// Directed bench for exu_muldiv_unit: results, tags, latency, backpressure, flush and async reset.
// Build with EXU_MDU_FAST_MUL_EN defined to check the single-cycle multiplier latency.
module tb_exu_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic [2:0]  req_op = '0;
    logic [31:0] req_src1 = '0;
    logic [31:0] req_src2 = '0;
    logic [4:0]  req_rd = '0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b0;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

`ifdef EXU_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    exu_muldiv_unit dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .req_rd(req_rd),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rd(rsp_rd),
        .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one request; the accept edge is the posedge this task returns after (+1).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        check("req_rdy_idle", {31'b0, req_rdy}, 32'd1);
        req_vld = 1'b1; req_op = op; req_src1 = a; req_src2 = b; req_rd = rd;
        @(posedge clk); #1;
        req_vld = 1'b0;
        req_op = 3'($urandom_range(0, 7));
        req_src1 = $urandom; req_src2 = $urandom;
        req_rd = 5'($urandom_range(0, 31));
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_vld && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_rsp();
        @(negedge clk); rsp_rdy = 1'b1;
        @(posedge clk); #1; rsp_rdy = 1'b0;
        check("idle_after_rsp", {31'b0, busy}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        exp_q.push_back(exp);
        issue(op, a, b, rd);
        wait_rsp(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_vld"}, {31'b0, rsp_vld}, 32'd1);
        check(tag, rsp_data, exp_q.pop_front());
        check({tag, "_rd"}, {27'b0, rsp_rd}, {27'b0, rd});
        release_rsp();
    endtask

    initial begin
        int lat, seen;
        logic [31:0] hold_data;

        repeat (3) @(posedge clk);
        #1;
        check("rst_vld",  {31'b0, rsp_vld}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_rd",   {27'b0, rsp_rd}, 32'd0);
        @(negedge clk); rst = 1'b0;
        #1 check("rdy_after_rst", {31'b0, req_rdy}, 32'd1);

        run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT);
        run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, MUL_LAT);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, MUL_LAT);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, MUL_LAT);
        run_op("mul_big",3'd0, 32'h0001_0003,  32'h0002_0005, 5'd9,  32'h000B_000F, MUL_LAT);
        run_op("mulh_neg",3'd1,32'hFFFF_FFFE,  32'h0000_0003, 5'd10, 32'hFFFF_FFFF, MUL_LAT);
        run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, DIV_LAT);
        run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, DIV_LAT);
        run_op("divu",   3'd5, 32'd100,        32'd7,         5'd7,  32'd14,        DIV_LAT);
        run_op("remu",   3'd7, 32'd100,        32'd7,         5'd8,  32'd2,         DIV_LAT);
        run_op("div_pn", 3'd4, 32'd7,          32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_pn", 3'd6, 32'd7,          32'hFFFF_FFFE, 5'd12, 32'd1,         DIV_LAT);
        run_op("divu_z", 3'd5, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 1);
        run_op("remu_z", 3'd7, 32'd5,          32'd0,         5'd14, 32'd5,         1);
        run_op("div_z",  3'd4, 32'hFFFF_FFF9,  32'd0,         5'd15, 32'hFFFF_FFFF, 1);
        run_op("rem_z",  3'd6, 32'hFFFF_FFF9,  32'd0,         5'd16, 32'hFFFF_FFF9, 1);
        run_op("div_ovf",3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1);
        run_op("rem_ovf",3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd18, 32'd0,         1);

        // Backpressure: response held for 10 cycles while a new request waits
        issue(3'd5, 32'd1000, 32'd9, 5'd21);
        wait_rsp(lat);
        check("bp_lat", 32'(lat), 32'(DIV_LAT));
        hold_data = 32'd111;
        @(negedge clk); req_vld = 1'b1; req_op = 3'd0; req_src1 = 32'd3; req_src2 = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_vld",  {31'b0, rsp_vld}, 32'd1);
            check("bp_data", rsp_data, hold_data);
            check("bp_rd",   {27'b0, rsp_rd}, 32'd21);
            check("bp_rdy",  {31'b0, req_rdy}, 32'd0);
        end
        req_vld = 1'b0;
        @(negedge clk); rsp_rdy = 1'b1;
        @(posedge clk); #1; rsp_rdy = 1'b0;
        check("bp_release_vld", {31'b0, rsp_vld}, 32'd0);
        check("bp_release_rdy", {31'b0, req_rdy}, 32'd1);

        // Flush during DIV: back to IDLE, no response ever appears
        issue(3'd4, 32'd12345, 32'd17, 5'd22);
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rsp_vld) seen++;
        end
        check("flush_no_rsp", 32'(seen), 32'd0);

        // Flush masks req_rdy in IDLE and blocks the accept
        @(negedge clk); flush = 1'b1; req_vld = 1'b1; req_op = 3'd5;
        req_src1 = 32'd4; req_src2 = 32'd0;
        #1 check("flush_mask_rdy", {31'b0, req_rdy}, 32'd0);
        @(posedge clk); #1;
        check("flush_no_accept", {31'b0, busy}, 32'd0);
        req_vld = 1'b0; flush = 1'b0;

        // Flush while a response is pending in DONE
        issue(3'd7, 32'd9, 32'd0, 5'd23);
        check("flushdone_vld", {31'b0, rsp_vld}, 32'd1);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flushdone_gone", {31'b0, rsp_vld}, 32'd0);

        // Asynchronous reset mid-multiply
        issue(3'd0, 32'd6, 32'd7, 5'd24);
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        check("arst_vld",  {31'b0, rsp_vld}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_data", rsp_data, 32'd0);
        check("arst_rd",   {27'b0, rsp_rd}, 32'd0);
        @(negedge clk); rst = 1'b0;
        run_op("mul_after_rst", 3'd0, 32'd6, 32'd7, 5'd25, 32'd42, MUL_LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
